// File: rtl/smem_arbiter_if.sv
// Screen-memory arbiter bus: CPU request side, VGA fetch side and the single memory port.
// The arbiter uses the slave modport; the surrounding system (CPU, VGA, memory) uses master.
interface smem_arbiter_if #(
    parameter int wordsize = 32,
    parameter int abits    = 11
) ();
    logic                cpu_req;
    logic                cpu_wr;
    logic [abits-1:0]    cpu_addr;
    logic [wordsize-1:0] cpu_wdata;
    logic [wordsize-1:0] cpu_rdata;
    logic                cpu_stall;
    logic                vga_req;
    logic [abits-1:0]    vga_addr;
    logic                vga_gnt;
    logic                vga_valid;
    logic [wordsize-1:0] vga_rdata;
    logic                mem_en;
    logic                mem_wr;
    logic [abits-1:0]    mem_addr;
    logic [wordsize-1:0] mem_wdata;
    logic [wordsize-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
        output cpu_rdata, cpu_stall, vga_gnt, vga_valid, vga_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
        input  cpu_rdata, cpu_stall, vga_gnt, vga_valid, vga_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/smem_arbiter.sv
// Shares the synchronous-read screen-memory port between the CPU and VGA fetch.
// VGA has priority; a saturating wait counter lets a stalled CPU win after maxwait cycles.
module smem_arbiter #(
    parameter int wordsize = 32,
    parameter int abits    = 11,
    parameter int maxwait  = 7
) (
    input  logic            clk,
    input  logic            reset,
    smem_arbiter_if.slave   bus
);
    localparam int WCW = (maxwait < 1) ? 1 : $clog2(maxwait + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(maxwait);
    localparam logic [WCW-1:0] WAIT_ONE = WCW'(1);

    typedef enum logic [0:0] {
        ST_IDLE        = 1'b0,
        ST_CPU_RD_DONE = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           vga_pend_q, vga_pend_d;
    logic           cpu_elig_s;
    logic           cpu_win_s;
    logic           vga_gnt_s;

    // Grant decision; reset suppresses both grants so the port is quiet while reset is held.
    always_comb begin
        cpu_elig_s = bus.cpu_req && (state_q != ST_CPU_RD_DONE) && !reset;
        cpu_win_s  = cpu_elig_s && (!bus.vga_req || (wait_cnt_q == WAIT_MAX));
        vga_gnt_s  = bus.vga_req && !cpu_win_s && !reset;
    end

    // Memory port drive and requester-facing outputs.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = {abits{1'b0}};
        bus.mem_wdata = {wordsize{1'b0}};
        if (cpu_win_s) begin
            bus.mem_en    = 1'b1;
            bus.mem_wr    = bus.cpu_wr;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (vga_gnt_s) begin
            bus.mem_en    = 1'b1;
            bus.mem_wr    = 1'b0;
            bus.mem_addr  = bus.vga_addr;
            bus.mem_wdata = {wordsize{1'b0}};
        end else begin
            bus.mem_en    = 1'b0;
        end

        bus.vga_gnt   = vga_gnt_s;
        bus.cpu_stall = bus.cpu_req && !(cpu_win_s && bus.cpu_wr)
                        && (state_q != ST_CPU_RD_DONE) && !reset;
        bus.cpu_rdata = (state_q == ST_CPU_RD_DONE) ? bus.mem_rdata : {wordsize{1'b0}};
        bus.vga_valid = vga_pend_q;
        bus.vga_rdata = vga_pend_q ? bus.mem_rdata : {wordsize{1'b0}};
    end

    // Next-state logic: a granted CPU read spends one cycle collecting its data.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        vga_pend_d = vga_gnt_s;

        case (state_q)
            ST_IDLE: begin
                if (cpu_win_s && !bus.cpu_wr) begin
                    state_d = ST_CPU_RD_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CPU_RD_DONE: state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase

        // A dropped request forgets its accumulated wait; the count saturates at maxwait.
        if (!bus.cpu_req || cpu_win_s) begin
            wait_cnt_d = {WCW{1'b0}};
        end else if (cpu_elig_s && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // State registers with synchronous reset, which also discards any in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= {WCW{1'b0}};
            vga_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            vga_pend_q <= vga_pend_d;
        end
    end
endmodule

// File: doc/smem_arbiter.md
Name: smem_arbiter

Overview:
- Shares the single synchronous-read port of screen memory between the CPU and the VGA character-fetch engine.
- The CPU side is driven from the memory-map decode for the screen-memory region (address bits [17:16] = 2'b10). This block stalls the CPU while the port is busy.
- VGA has priority because it has a real-time deadline. A wait counter guarantees the CPU is never starved.

Parameters:
- wordsize, 32, data width of screen memory words and CPU data.
- abits, 11, screen memory address width (1200 locations used).
- maxwait, 7, consecutive stalled cycles after which a pending CPU request beats VGA.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- cpu_req  input  1  CPU access to screen memory this cycle (decoded region hit).
- cpu_wr  input  1  1 = write, 0 = read; valid with cpu_req.
- cpu_addr  input  abits  CPU word address.
- cpu_wdata  input  wordsize  CPU write data.
- cpu_rdata  output  wordsize  CPU read data; valid when the read completes.
- cpu_stall  output  1  freezes the CPU PC and state while high.
- vga_req  input  1  VGA fetch request; held high until granted.
- vga_addr  input  abits  VGA fetch address.
- vga_gnt  output  1  VGA request accepted this cycle.
- vga_valid  output  1  vga_rdata valid (one cycle after vga_gnt).
- vga_rdata  output  wordsize  VGA fetch data.
- mem_en  output  1  memory port access this cycle.
- mem_wr  output  1  memory write enable.
- mem_addr  output  abits  memory address.
- mem_wdata  output  wordsize  memory write data.
- mem_rdata  input  wordsize  memory read data, one cycle after the address.

Behaviour:
- Memory model: the address presented in cycle N yields mem_rdata in cycle N+1. A write commits at the clock edge ending cycle N.
- States: IDLE and CPU_RD_DONE. A separate flop vga_pend records a VGA grant made in the previous cycle.
- Grant decision is combinational each cycle:
  - cpu_elig = cpu_req and state != CPU_RD_DONE.
  - cpu_win = cpu_elig and (not vga_req or wait_cnt == maxwait).
  - vga_gnt = vga_req and not cpu_win.
- Port drive:
  - On cpu_win: mem_en=1, mem_wr=cpu_wr, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - On vga_gnt: mem_en=1, mem_wr=0, mem_addr=vga_addr.
  - Otherwise: mem_en=0, mem_wr=0, and mem_addr/mem_wdata=0.
- CPU write: completes in its grant cycle, so cpu_stall=0 that cycle. Zero added latency when uncontended.
- CPU read:
  - Grant cycle N: cpu_stall=1, next state CPU_RD_DONE.
  - Cycle N+1: cpu_rdata=mem_rdata, cpu_stall=0, next state IDLE.
  - In CPU_RD_DONE the port is free for a VGA grant; cpu_req is ignored for arbitration that cycle.
- cpu_stall = cpu_req and not (cpu_win and cpu_wr) and not (state == CPU_RD_DONE).
- cpu_rdata = mem_rdata in CPU_RD_DONE, else 0.
- vga_pend <= vga_gnt. vga_valid = vga_pend. vga_rdata = mem_rdata when vga_pend, else 0.
- wait_cnt register, width clog2(maxwait+1):
  - Increments while cpu_elig and not cpu_win.
  - Saturates at maxwait.
  - Clears on cpu_win or when cpu_req=0.
- Simultaneous cpu_req and vga_req with wait_cnt < maxwait: VGA wins and the CPU stalls.
- Simultaneous requests with wait_cnt == maxwait: CPU wins, vga_gnt=0, and VGA keeps its request high.
- Worst-case CPU latency: maxwait+1 cycles for a write, maxwait+2 cycles for a read.
- cpu_req dropping mid-wait (not legal from the CPU, but tolerated): wait_cnt clears and no access is issued.
- Reset (synchronous, active-high):
  - state=IDLE, wait_cnt=0, vga_pend=0.
  - While reset is high, mem_en, mem_wr, vga_gnt and cpu_stall are forced to 0.
  - Reset during CPU_RD_DONE or with vga_pend=1 discards the in-flight read, so no valid appears after reset.

Test Plan:
- CPU write only: cpu_req=1, cpu_wr=1, addr=0x005, wdata=0x0000000A -> same cycle mem_en=1, mem_wr=1, mem_addr=0x005, cpu_stall=0.
- CPU read only: addr=0x010 with memory holding 0x3 -> cycle N: cpu_stall=1, mem_addr=0x010; cycle N+1: cpu_stall=0, cpu_rdata=0x3.
- VGA stream alone: vga_req held with addr 0,1,2 -> vga_gnt=1 each cycle; vga_valid=1 one cycle later carrying words 0,1,2.
- Contention: vga_req continuous plus CPU write -> CPU stalls 7 cycles (wait_cnt 0..7), granted in cycle 8; vga_gnt=0 in that cycle only.
- CPU read under contention: after the CPU grant, VGA is granted in CPU_RD_DONE. cpu_rdata and vga_valid never refer to the same cycle's address.
- Reset asserted in CPU_RD_DONE with vga_pend=1 -> next cycle vga_valid=0, cpu_stall=0, mem_en=0, state IDLE.
